// File: rtl/iir_inverse.sv
// iir_inverse: inverse of y(n) = A*y(n-1) + 2^B_SHIFT*x(n); recovers clamped x(n)
// through a 2-stage valid/ready pipeline with flush and error reporting.
`default_nettype none

module iir_inverse #(
  parameter logic signed [7:0] A       = -8'sd1,
  parameter int                B_SHIFT = 2,
  parameter int                IN_W    = 16,
  parameter int                OUT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             flush,
  output logic             rem_err,
  output logic             sat,
  output logic [15:0]      err_count,
  input  logic             clr_err
);

  localparam int D_W = IN_W + 9;
  localparam logic [D_W-1:0]        REM_MASK = D_W'((64'd1 << B_SHIFT) - 64'd1);
  localparam logic signed [D_W-1:0] OUT_MAX  = D_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [D_W-1:0] OUT_MIN  = ~OUT_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic signed [IN_W-1:0]  r_y_prev;
  logic signed [D_W-1:0]   r_d;
  logic                    r_s1_valid;
  logic                    r_out_valid;
  logic [OUT_W-1:0]        r_out_data;
  logic                    r_rem_err, r_sat;
  logic [15:0]             r_err_count;

  logic                    w_out_free, w_s1_adv, w_ready_en, w_in_ready, w_accept, w_clr_hist;
  logic signed [D_W-1:0]   w_a_ext, w_y_ext, w_in_ext, w_d, w_q;
  logic                    w_rem_nz, w_hi, w_lo;
  logic [OUT_W-1:0]        w_clamped;

  assign w_out_free = !r_out_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_out_free;
  assign w_ready_en = (r_state != S_DRAIN);
  assign w_in_ready = !rst && w_ready_en && (!r_s1_valid || w_s1_adv);
  assign w_accept   = in_valid && w_in_ready;

  // Full-precision difference: IN_W + 8-bit product plus one guard bit.
  assign w_a_ext  = {{(D_W-8){A[7]}}, A};
  assign w_y_ext  = {{(D_W-IN_W){r_y_prev[IN_W-1]}}, r_y_prev};
  assign w_in_ext = {{(D_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign w_d      = w_in_ext - w_a_ext * w_y_ext;

  assign w_q       = r_d >>> B_SHIFT;
  assign w_rem_nz  = |(r_d & REM_MASK);
  assign w_hi      = (w_q > OUT_MAX);
  assign w_lo      = (w_q < OUT_MIN);
  assign w_clamped = w_hi ? OUT_MAX[OUT_W-1:0] :
                     w_lo ? OUT_MIN[OUT_W-1:0] : w_q[OUT_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_clr_hist  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush) w_clr_hist = 1'b1;
        if (w_accept) w_state_nxt = flush ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (flush) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_s1_valid && !r_out_valid) begin
          w_clr_hist  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_y_prev   <= '0;
      r_d        <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_d        <= w_d;
        r_y_prev   <= in_data;
        r_s1_valid <= 1'b1;
      end else begin
        if (w_s1_adv)   r_s1_valid <= 1'b0;
        if (w_clr_hist) r_y_prev   <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_clamped;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Clear takes priority over any flag or count produced on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem_err   <= 1'b0;
      r_sat       <= 1'b0;
      r_err_count <= '0;
    end else if (clr_err) begin
      r_rem_err   <= 1'b0;
      r_sat       <= 1'b0;
      r_err_count <= '0;
    end else if (w_s1_adv) begin
      if (w_rem_nz) begin
        r_rem_err <= 1'b1;
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      end
      if (w_hi || w_lo) r_sat <= 1'b1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign rem_err   = r_rem_err;
  assign sat       = r_sat;
  assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_iir_inverse.sv
// tb_iir_inverse: directed and randomized checks of iir_inverse against a
// floor-division reference model with an expected-output queue.
`default_nettype none

module tb_iir_inverse;

  localparam logic signed [7:0] A_P = -8'sd1;
  localparam int BS    = 2;
  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int OMAX  = (1 << (OUT_W - 1)) - 1;
  localparam int OMIN  = -(1 << (OUT_W - 1));

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             flush = 1'b0;
  logic             rem_err;
  logic             sat;
  logic [15:0]      err_count;
  logic             clr_err = 1'b0;

  iir_inverse #(.A(A_P), .B_SHIFT(BS), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .rem_err(rem_err), .sat(sat), .err_count(err_count),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];
  int m_yp = 0;
  int m_cnt = 0;
  bit m_rem = 0;
  bit m_sat = 0;
  bit g_ir, g_acc, last_stall;
  int g_last_xfer;
  logic signed [OUT_W-1:0] last_out;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // x = floor((y - A*yp) / 2^BS), then clipped to the output range.
  function automatic int model_x(input int y, input int yp, output bit rnz, output bit clip);
    int d, q, b;
    b = 1 << BS;
    d = y - int'(A_P) * yp;
    q = d / b;
    if ((d % b) != 0 && d < 0) q = q - 1;
    rnz  = (d != q * b);
    clip = 1'b0;
    if (q > OMAX) begin q = OMAX; clip = 1'b1; end
    else if (q < OMIN) begin q = OMIN; clip = 1'b1; end
    return q;
  endfunction

  // One cycle: drive at the falling edge, observe 1 ns later, advance to the next falling edge.
  task automatic step(input bit v, input int y, input bit ordy, input bit fl, input bit clr);
    int x;
    bit rnz, clip;
    in_valid  = v;
    in_data   = y[IN_W-1:0];
    out_ready = ordy;
    flush     = fl;
    clr_err   = clr;
    #1;
    g_ir  = in_ready;
    g_acc = v && in_ready;
    if (last_stall && out_valid) chk("hold", int'($signed(out_data)), int'(last_out));
    if (out_valid && out_ready) begin
      g_last_xfer = int'($signed(out_data));
      if (exp_q.size() == 0) chk("exp_avail", exp_q.size(), 1);
      else chk("data", g_last_xfer, exp_q.pop_front());
    end
    if (g_acc) begin
      x = model_x(y, m_yp, rnz, clip);
      exp_q.push_back(x);
      m_yp  = y;
      m_cnt = m_cnt + int'(rnz);
      m_rem = m_rem | rnz;
      m_sat = m_sat | clip;
    end
    if (fl) m_yp = 0;
    if (clr) begin m_cnt = 0; m_rem = 0; m_sat = 0; end
    last_stall = out_valid && !out_ready;
    last_out   = $signed(out_data);
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    while ((exp_q.size() != 0 || !g_ir) && k < 50) begin
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      k++;
    end
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    m_yp = 0; m_cnt = 0; m_rem = 0; m_sat = 0;
    last_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int ys1[5] = '{-28, 4, -24, 8, -20};
  int ys4[4] = '{-28, 4, -24, 8};

  initial begin
    int idx, k;
    last_stall = 1'b0;
    // Reset values
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_rem_err", rem_err, 0);
    chk("rst_sat", sat, 0);
    chk("rst_err_count", err_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    @(negedge clk);

    // Unstalled stream, 2-cycle latency
    step(1'b1, ys1[0], 1'b1, 1'b0, 1'b0);
    chk("lat_e0", out_valid, 0);
    step(1'b1, ys1[1], 1'b1, 1'b0, 1'b0);
    chk("lat_e1", out_valid, 1);
    chk("first_x", int'($signed(out_data)), -7);
    for (int i = 2; i < 5; i++) step(1'b1, ys1[i], 1'b1, 1'b0, 1'b0);
    drain();
    chk("t1_last", g_last_xfer, -3);
    chk("t1_rem", rem_err, 0);
    chk("t1_sat", sat, 0);

    // Inexact division, then clear
    do_reset();
    step(1'b1, 5, 1'b1, 1'b0, 1'b0);
    drain();
    chk("t2_x", g_last_xfer, 1);
    chk("t2_rem", rem_err, 1);
    chk("t2_cnt", err_count, 1);
    step(1'b0, 0, 1'b1, 1'b0, 1'b1);
    chk("t2_rem_clr", rem_err, 0);
    chk("t2_cnt_clr", err_count, 0);

    // Saturation both ways
    do_reset();
    step(1'b1, 1000, 1'b1, 1'b0, 1'b0);
    step(1'b1, -3000, 1'b1, 1'b0, 1'b0);
    drain();
    chk("t3_x", g_last_xfer, -128);
    chk("t3_sat", sat, 1);

    // Backpressure: out_ready low in cycles 2..5
    do_reset();
    idx = 0;
    for (int c = 1; c <= 10; c++) begin
      step(idx < 4, (idx < 4) ? ys4[idx] : 0, !(c >= 2 && c <= 5), 1'b0, 1'b0);
      if (c >= 3 && c <= 5) chk("bp_full", g_ir, 0);
      if (g_acc) idx++;
    end
    chk("bp_sent", idx, 4);
    drain();
    chk("bp_last", g_last_xfer, -4);

    // Flush: drain holds off input until empty, then history restarts at 0
    do_reset();
    step(1'b1, -28, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 1'b0, 1'b0, 1'b0);
      chk("fl_blocked", g_ir, 0);
    end
    k = 0;
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    while (!g_ir && k < 20) begin
      if (exp_q.size() != 0) chk("fl_blocked2", g_ir, 0);
      step(1'b0, 0, 1'b1, 1'b0, 1'b0);
      k++;
    end
    chk("fl_reopen", g_ir, 1);
    chk("fl_empty", exp_q.size(), 0);
    step(1'b1, 8, 1'b1, 1'b0, 1'b0);
    drain();
    chk("fl_x", g_last_xfer, 2);

    // Asynchronous reset with two samples in flight
    step(1'b1, -28, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 0);
    exp_q.delete();
    m_yp = 0; m_cnt = 0; m_rem = 0; m_sat = 0;
    last_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    step(1'b1, 4, 1'b1, 1'b0, 1'b0);
    drain();
    chk("ar_x", g_last_xfer, 1);

    // Randomized traffic with backpressure and flushes
    do_reset();
    for (int c = 0; c < 800; c++) begin
      int y;
      if ($urandom_range(0, 9) == 0) y = int'($urandom_range(0, 65535)) - 32768;
      else y = int'($urandom_range(0, 1200)) - 600;
      step($urandom_range(0, 9) < 7, y, $urandom_range(0, 9) < 7,
           $urandom_range(0, 49) == 0, 1'b0);
    end
    drain();
    chk("rnd_cnt", err_count, m_cnt);
    chk("rnd_rem", rem_err, int'(m_rem));
    chk("rnd_sat", sat, int'(m_sat));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
